// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: scancode-set-2 parser feeding the game logic.
// Decodes E0/F0/E1 prefixes, tracks held direction/fire keys and queues
// make events in a first-word-fall-through FIFO with a registered head.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | waiting for a scancode or a prefix byte
//   S_EXT    | E0 seen, next byte is an extended make (or F0)
//   S_BRK    | F0 seen, next byte is a non-extended break
//   S_EXT_BRK| E0 F0 seen, next byte is an extended break
//   S_SKIP   | swallowing the remaining bytes of the Pause sequence
module ps2_key_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int REPEAT_FILTER  = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_ps2_key_pressed,
  input  logic [7:0]                    i_ps2_key_data,
  output logic [3:0]                    o_dir_held,
  output logic                          o_space_held,
  output logic                          o_evt_valid,
  output logic [8:0]                    o_evt_data,
  input  logic                          i_evt_pop,
  output logic [$clog2(FIFO_DEPTH):0]   o_evt_count,
  output logic                          o_evt_overflow,
  input  logic                          i_ovf_clr,
  output logic                          o_sync_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [2:0]      r_skip_cnt, w_skip_nxt;
  logic [TW-1:0]   r_tmo;
  logic            r_sync_error;

  logic [3:0]      r_arrow, r_wasd;
  logic            r_space;

  logic [8:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [8:0]      r_head;
  logic            r_overflow;

  logic            w_make, w_break, w_ext, w_timeout;
  logic [3:0]      w_hit_arrow, w_hit_wasd;
  logic            w_hit_space, w_tracked, w_already, w_push;
  logic            w_do_push, w_do_pop;
  logic [AW-1:0]   w_rd_inc;
  logic [8:0]      w_push_data;

  // Parser next-state: byte classification, Pause skipping and prefix timeout
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_ext       = 1'b0;
    w_timeout   = 1'b0;
    if (i_ps2_key_pressed) begin
      case (r_state)
        S_IDLE: begin
          if (i_ps2_key_data == 8'hE0) begin
            w_state_nxt = S_EXT;
          end else if (i_ps2_key_data == 8'hF0) begin
            w_state_nxt = S_BRK;
          end else if (i_ps2_key_data == 8'hE1) begin
            w_state_nxt = S_SKIP;
            w_skip_nxt  = 3'd7;
          end else begin
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          if (i_ps2_key_data == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else if (i_ps2_key_data != 8'hE0) begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          w_break     = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_EXT_BRK: begin
          w_break     = 1'b1;
          w_ext       = 1'b1;
          w_state_nxt = S_IDLE;
        end
        S_SKIP: begin
          w_skip_nxt = r_skip_cnt - 3'd1;
          if (r_skip_cnt <= 3'd1) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
      w_timeout   = 1'b1;
      w_state_nxt = S_IDLE;
    end
  end

  // Tracked-key lookup and repeat filtering for the current byte
  always_comb begin
    w_hit_arrow = 4'b0000;
    w_hit_wasd  = 4'b0000;
    w_hit_space = 1'b0;
    if (w_ext) begin
      w_hit_arrow[3] = (i_ps2_key_data == 8'h75);
      w_hit_arrow[2] = (i_ps2_key_data == 8'h72);
      w_hit_arrow[1] = (i_ps2_key_data == 8'h6B);
      w_hit_arrow[0] = (i_ps2_key_data == 8'h74);
    end else begin
      w_hit_wasd[3] = (i_ps2_key_data == 8'h1D);
      w_hit_wasd[2] = (i_ps2_key_data == 8'h1B);
      w_hit_wasd[1] = (i_ps2_key_data == 8'h1C);
      w_hit_wasd[0] = (i_ps2_key_data == 8'h23);
      w_hit_space   = (i_ps2_key_data == 8'h29);
    end
    w_tracked = (|w_hit_arrow) | (|w_hit_wasd) | w_hit_space;
    w_already = (|(w_hit_arrow & r_arrow)) | (|(w_hit_wasd & r_wasd)) |
                (w_hit_space & r_space);
    w_push    = w_make & ~((REPEAT_FILTER != 0) & w_tracked & w_already);
  end

  // FIFO handshake: a pop frees the slot a same-cycle push needs when full
  always_comb begin
    w_do_pop    = i_evt_pop & (r_count != '0);
    w_do_push   = w_push & ((r_count != CW'(FIFO_DEPTH)) | w_do_pop);
    w_rd_inc    = r_rd_ptr + AW'(1);
    w_push_data = {w_ext, i_ps2_key_data};
  end

  // Parser state, skip counter, prefix timer and sync_error pulse
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_skip_cnt   <= '0;
      r_tmo        <= '0;
      r_sync_error <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_skip_cnt   <= w_skip_nxt;
      r_sync_error <= w_timeout;
      if (i_ps2_key_pressed || r_state == S_IDLE || w_timeout) r_tmo <= '0;
      else                                                   r_tmo <= r_tmo + TW'(1);
    end
  end

  // Held-key flags: makes set, breaks clear, untracked codes hit nothing
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_arrow <= '0;
      r_wasd  <= '0;
      r_space <= 1'b0;
    end else if (w_make) begin
      r_arrow <= r_arrow | w_hit_arrow;
      r_wasd  <= r_wasd  | w_hit_wasd;
      r_space <= r_space | w_hit_space;
    end else if (w_break) begin
      r_arrow <= r_arrow & ~w_hit_arrow;
      r_wasd  <= r_wasd  & ~w_hit_wasd;
      r_space <= r_space & ~w_hit_space;
    end
  end

  // Event storage; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers, occupancy, registered head and sticky overflow
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= w_rd_inc;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_do_pop) begin
        if (r_count != CW'(1))  r_head <= r_mem[w_rd_inc];
        else if (w_do_push)     r_head <= w_push_data;
      end else if (r_count == '0 && w_do_push) begin
        r_head <= w_push_data;
      end
      if (w_push && !w_do_push) r_overflow <= 1'b1;
      else if (i_ovf_clr)       r_overflow <= 1'b0;
    end
  end

  assign o_dir_held     = r_arrow | r_wasd;
  assign o_space_held   = r_space;
  assign o_evt_valid    = (r_count != '0);
  assign o_evt_data     = r_head;
  assign o_evt_count    = r_count;
  assign o_evt_overflow = r_overflow;
  assign o_sync_error   = r_sync_error;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: stimulus pushes expected events,
// a monitor pops and compares whenever the DUT head is consumed.
module tb_ps2_key_decoder;
  localparam int DEPTH = 8;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pressed = 1'b0;
  logic [7:0] kdata = 8'h00;
  logic       pop_mon = 1'b0;
  logic       pop_stim = 1'b0;
  logic       evt_pop;
  logic       ovf_clr = 1'b0;
  logic [3:0] dir_held;
  logic       space_held, evt_valid, evt_overflow, sync_error;
  logic [8:0] evt_data;
  logic [3:0] evt_count;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  bit         auto_en = 1'b0;

  assign evt_pop = pop_mon | pop_stim;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .REPEAT_FILTER(1)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_ps2_key_pressed(pressed), .i_ps2_key_data(kdata),
    .o_dir_held(dir_held), .o_space_held(space_held),
    .o_evt_valid(evt_valid), .o_evt_data(evt_data), .i_evt_pop(evt_pop),
    .o_evt_count(evt_count), .o_evt_overflow(evt_overflow),
    .i_ovf_clr(ovf_clr), .o_sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: decide auto-pop, and compare the head on every consumed entry
  initial begin
    forever begin
      @(negedge clk);
      #1;
      pop_mon = auto_en && evt_valid;
      if (evt_valid && (pop_mon || pop_stim)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got %0h expected none", evt_data);
        end else begin
          check("sb_evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    pressed = 1'b1;
    kdata   = b;
    @(posedge clk);
    @(negedge clk);
    pressed = 1'b0;
  endtask

  task automatic pulse_clr();
    ovf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    auto_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (!evt_valid && exp_q.size() == 0) break;
    end
    auto_en = 1'b0;
    check("drain_count", 32'(evt_count), 0);
    check("drain_queue", 32'(exp_q.size()), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dir"},   32'(dir_held), 0);
    check({tag, "_space"}, 32'(space_held), 0);
    check({tag, "_valid"}, 32'(evt_valid), 0);
    check({tag, "_data"},  32'(evt_data), 0);
    check({tag, "_count"}, 32'(evt_count), 0);
    check({tag, "_ovf"},   32'(evt_overflow), 0);
    check({tag, "_sync"},  32'(sync_error), 0);
  endtask

  initial begin
    int first_idx;
    int pulses;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Extended make then extended break of up-arrow
    send(8'hE0); exp_q.push_back(9'h175); send(8'h75);
    check("up_dir", 32'(dir_held), 32'h8);
    check("up_count", 32'(evt_count), 1);
    check("up_head", 32'(evt_data), 32'h175);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_rel_dir", 32'(dir_held), 0);
    check("up_rel_count", 32'(evt_count), 1);
    drain();

    // Typematic repeats of W are filtered
    exp_q.push_back(9'h01D);
    send(8'h1D); send(8'h1D); send(8'h1D);
    check("w_dir", 32'(dir_held), 32'h8);
    check("w_count", 32'(evt_count), 1);
    send(8'hF0); send(8'h1D);
    check("w_rel_dir", 32'(dir_held), 0);
    drain();

    // Up-arrow and W both held: releasing W keeps up direction
    send(8'hE0); exp_q.push_back(9'h175); send(8'h75);
    exp_q.push_back(9'h01D); send(8'h1D);
    send(8'hF0); send(8'h1D);
    check("or_dir", 32'(dir_held), 32'h8);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("or_rel_dir", 32'(dir_held), 0);
    drain();

    // Nine makes into an 8-deep FIFO: last one dropped, overflow sticky
    for (int c = 8'h15; c <= 8'h1D; c++) begin
      if (c <= 8'h1C) exp_q.push_back(9'(c));
      send(8'(c));
    end
    check("full_count", 32'(evt_count), 8);
    check("full_ovf", 32'(evt_overflow), 1);
    check("full_dir", 32'(dir_held), 32'hE);
    drain();
    check("ovf_sticky", 32'(evt_overflow), 1);
    pulse_clr();
    check("ovf_cleared", 32'(evt_overflow), 0);
    send(8'hF0); send(8'h1B);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h1D);
    check("wasd_rel_dir", 32'(dir_held), 0);

    // Overflow beats a same-cycle clear; then push+pop on a full FIFO
    for (int c = 8'h30; c <= 8'h37; c++) begin
      exp_q.push_back(9'(c));
      send(8'(c));
    end
    check("fill_count", 32'(evt_count), 8);
    check("fill_ovf", 32'(evt_overflow), 0);
    ovf_clr = 1'b1;
    send(8'h38);
    ovf_clr = 1'b0;
    check("ovf_wins", 32'(evt_overflow), 1);
    check("ovf_wins_count", 32'(evt_count), 8);
    pulse_clr();
    check("ovf_clr2", 32'(evt_overflow), 0);
    pop_stim = 1'b1;
    exp_q.push_back(9'h039);
    send(8'h39);
    pop_stim = 1'b0;
    check("pushpop_count", 32'(evt_count), 8);
    check("pushpop_ovf", 32'(evt_overflow), 0);
    check("pushpop_head", 32'(evt_data), 32'h031);
    drain();

    // Pause sequence produces nothing; the following space is a make
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_count", 32'(evt_count), 0);
    check("pause_dir", 32'(dir_held), 0);
    exp_q.push_back(9'h029);
    send(8'h29);
    check("space_held", 32'(space_held), 1);
    check("space_count", 32'(evt_count), 1);
    drain();
    send(8'hF0); send(8'h29);
    check("space_rel", 32'(space_held), 0);

    // Prefix timeout after a lone E0
    send(8'hE0);
    first_idx = 0;
    pulses = 0;
    for (int i = 1; i <= 3 * TMO; i++) begin
      if (i > 1) @(negedge clk);
      if (sync_error) begin
        pulses++;
        if (first_idx == 0) first_idx = i;
      end
    end
    check("tmo_pulses", 32'(pulses), 1);
    check("tmo_when", 32'(first_idx), TMO + 1);
    exp_q.push_back(9'h075);
    send(8'h75);
    check("tmo_dir", 32'(dir_held), 0);
    check("tmo_count", 32'(evt_count), 1);
    drain();

    // Reset in the middle of a break sequence
    send(8'h29);
    send(8'hF0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    check_all_zero("midrst");
    rst = 1'b0;
    exp_q.push_back(9'h029);
    send(8'h29);
    check("midrst_space", 32'(space_held), 1);
    check("midrst_count", 32'(evt_count), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
